// File: rtl/dispatch_pkg.sv
// Shared types and constants for the UART command dispatcher.
package dispatch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRun,
        StReply,
        StDrain
    } state_e;

    localparam logic [7:0] DefNakByte = 8'h3F;
    localparam logic [7:0] DefTmoByte = 8'hEE;
    localparam logic [7:0] NopCode    = 8'h00;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_lookup.sv
// Combinational command-code table match; the lowest matching client index wins.
module cmd_lookup #(
    parameter int unsigned N_CLIENTS = 5,
    parameter int unsigned DATA_W    = 8
) (
    input  logic [DATA_W-1:0]           cmd,
    input  logic [N_CLIENTS*DATA_W-1:0] codes,
    output logic [N_CLIENTS-1:0]        onehot,
    output logic                        hit
);

    always_comb begin
        onehot = '0;
        hit    = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (!hit && (codes[i*DATA_W +: DATA_W] == cmd)) begin
                onehot[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// UART command dispatcher: activates the client owning a received command code and
// arbitrates uart_tx between that client and NAK/timeout replies.
module cmd_dispatcher
    import dispatch_pkg::*;
#(
    parameter int unsigned                   N_CLIENTS      = 5,
    parameter int unsigned                   DATA_W         = 8,
    parameter logic [N_CLIENTS*DATA_W-1:0]   CMD_CODES      = {8'h72, 8'h71, 8'h22, 8'h21, 8'h11},
    parameter int unsigned                   TIMEOUT_CYCLES = 50_000_000,
    parameter logic [DATA_W-1:0]             NAK_BYTE       = DATA_W'(DefNakByte),
    parameter logic [DATA_W-1:0]             TMO_BYTE       = DATA_W'(DefTmoByte)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_ready,
    input  logic [DATA_W-1:0]             rx_data,
    input  logic                          tx_active,
    input  logic                          tx_done,
    output logic [DATA_W-1:0]             tx_data,
    output logic                          tx_start,
    output logic [N_CLIENTS-1:0]          client_activate,
    input  logic [N_CLIENTS-1:0]          client_done,
    input  logic [N_CLIENTS*DATA_W-1:0]   client_tx_data,
    input  logic [N_CLIENTS-1:0]          client_tx_start,
    output logic [DATA_W-1:0]             cur_cmd,
    output logic                          busy,
    output logic [7:0]                    err_count
);

    state_e              state_q;
    logic [DATA_W-1:0]   cmd_q;
    logic [DATA_W-1:0]   reply_q;
    logic                sent_q;
    logic [31:0]         tmo_q;

    logic [N_CLIENTS-1:0] hit_onehot;
    logic                 hit;
    logic [DATA_W-1:0]    act_data;
    logic                 act_start;
    logic                 act_done;
    logic                 tmo_hit;

    cmd_lookup #(
        .N_CLIENTS (N_CLIENTS),
        .DATA_W    (DATA_W)
    ) u_lookup (
        .cmd    (cmd_q),
        .codes  (CMD_CODES),
        .onehot (hit_onehot),
        .hit    (hit)
    );

    // Activate is one-hot, so an AND-OR mux selects the running client's signals.
    always_comb begin
        act_data  = '0;
        act_start = 1'b0;
        act_done  = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (client_activate[i]) begin
                act_data  = act_data | client_tx_data[i*DATA_W +: DATA_W];
                act_start = act_start | client_tx_start[i];
                act_done  = act_done | client_done[i];
            end
        end
    end

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TIMEOUT_CYCLES - 1);
    assign busy    = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= StIdle;
            cmd_q           <= '0;
            reply_q         <= '0;
            sent_q          <= 1'b0;
            tmo_q           <= '0;
            tx_data         <= '0;
            tx_start        <= 1'b0;
            client_activate <= '0;
            cur_cmd         <= '0;
            err_count       <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rx_ready && (rx_data != DATA_W'(NopCode))) begin
                        cmd_q   <= rx_data;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        client_activate <= hit_onehot;
                        cur_cmd         <= cmd_q;
                        tmo_q           <= '0;
                        state_q         <= StRun;
                    end else begin
                        reply_q   <= NAK_BYTE;
                        sent_q    <= 1'b0;
                        err_count <= sat_inc(err_count);
                        state_q   <= StReply;
                    end
                end
                StRun: begin
                    // A done arriving on the timeout cycle is a clean finish.
                    if (act_done) begin
                        client_activate <= '0;
                        state_q         <= StDrain;
                    end else if (tmo_hit) begin
                        client_activate <= '0;
                        reply_q         <= TMO_BYTE;
                        sent_q          <= 1'b0;
                        err_count       <= sat_inc(err_count);
                        state_q         <= StReply;
                    end else begin
                        tmo_q    <= tmo_q + 32'd1;
                        tx_data  <= act_data;
                        tx_start <= act_start;
                    end
                end
                StReply: begin
                    if (!sent_q) begin
                        if (!tx_active) begin
                            tx_start <= 1'b1;
                            tx_data  <= reply_q;
                            sent_q   <= 1'b1;
                        end
                    end else if (tx_done) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!tx_active && !rx_ready) begin
                        cur_cmd <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher with a TX-byte scoreboard.
module tb_cmd_dispatcher;

    localparam int unsigned N = 5;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           rx_ready = 1'b0;
    logic [W-1:0]   rx_data = '0;
    logic           tx_active = 1'b0;
    logic           tx_done = 1'b0;
    logic [N-1:0]   client_done = '0;
    logic [N*W-1:0] client_tx_data = '0;
    logic [N-1:0]   client_tx_start = '0;

    logic [W-1:0]   tx_data;
    logic           tx_start;
    logic [N-1:0]   client_activate;
    logic [W-1:0]   cur_cmd;
    logic           busy;
    logic [7:0]     err_count;

    logic [W-1:0]   d2_tx_data;
    logic           d2_tx_start;
    logic [N-1:0]   d2_activate;
    logic [W-1:0]   d2_cur_cmd;
    logic           d2_busy;
    logic [7:0]     d2_err_count;

    int checks = 0;
    int errors = 0;
    int n;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    always #5 clk = ~clk;

    cmd_dispatcher #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_ready        (rx_ready),
        .rx_data         (rx_data),
        .tx_active       (tx_active),
        .tx_done         (tx_done),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .client_activate (client_activate),
        .client_done     (client_done),
        .client_tx_data  (client_tx_data),
        .client_tx_start (client_tx_start),
        .cur_cmd         (cur_cmd),
        .busy            (busy),
        .err_count       (err_count)
    );

    // Duplicate 8'h21 at indices 1 and 4.
    cmd_dispatcher #(
        .CMD_CODES      (40'h21_71_22_21_11),
        .TIMEOUT_CYCLES (100)
    ) dut_dup (
        .clk             (clk),
        .reset           (reset),
        .rx_ready        (rx_ready),
        .rx_data         (rx_data),
        .tx_active       (tx_active),
        .tx_done         (tx_done),
        .tx_data         (d2_tx_data),
        .tx_start        (d2_tx_start),
        .client_activate (d2_activate),
        .client_done     (client_done),
        .client_tx_data  (client_tx_data),
        .client_tx_start (client_tx_start),
        .cur_cmd         (d2_cur_cmd),
        .busy            (d2_busy),
        .err_count       (d2_err_count)
    );

    // Every cycle with tx_start high is one byte handed to uart_tx.
    always @(negedge clk) begin
        if (tx_start === 1'b1) obs_q.push_back(tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            chk(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        chk({tag, "_extra_tx"}, obs_q.size(), 0);
        chk({tag, "_missing_tx"}, exp_q.size(), 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        rx_data  = '0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_act", client_activate, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_err", err_count, 0);
        chk("rst_cur_cmd", cur_cmd, 0);
        reset = 1'b1;
        tick();

        // Client 3 runs and sends two bytes
        send_cmd(8'h71);
        chk("t1_act_lookup", client_activate, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_act", client_activate, 5'b01000);
        chk("t1_cur_cmd", cur_cmd, 8'h71);
        client_tx_data[3*W +: W] = 8'hA5;
        client_tx_start[3]       = 1'b1;
        client_tx_data[1*W +: W] = 8'h99;
        client_tx_start[1]       = 1'b1;
        client_done[0]           = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        chk("t1_tx_data", tx_data, 8'hA5);
        chk("t1_tx_start", tx_start, 1);
        chk("t1_other_done_ignored", client_activate, 5'b01000);
        client_tx_start = '0;
        client_done     = '0;
        tick();
        chk("t1_tx_start_low", tx_start, 0);
        client_tx_data[3*W +: W] = 8'h5A;
        client_tx_start[3]       = 1'b1;
        exp_q.push_back(8'h5A);
        tick();
        client_tx_start = '0;
        client_done[3]  = 1'b1;
        tick();
        client_done = '0;
        chk("t1_act_off", client_activate, 0);
        chk("t1_drain_busy", busy, 1);
        tx_active = 1'b1;
        tick();
        chk("t1_drain_hold", busy, 1);
        tx_active = 1'b0;
        tick();
        chk("t1_idle", busy, 0);
        chk("t1_cur_cmd_clr", cur_cmd, 0);
        sb_check("t1_sb");

        // Unknown command gets a NAK
        exp_q.push_back(8'h3F);
        send_cmd(8'h55);
        tx_active = 1'b1;
        tick();
        chk("t2_err", err_count, 1);
        chk("t2_act", client_activate, 0);
        tick();
        chk("t2_wait_uart", tx_start, 0);
        tx_active = 1'b0;
        tick();
        chk("t2_tx_start", tx_start, 1);
        chk("t2_tx_data", tx_data, 8'h3F);
        tx_active = 1'b1;
        tick();
        chk("t2_pulse_end", tx_start, 0);
        tx_done   = 1'b1;
        tx_active = 1'b0;
        tick();
        tx_done = 1'b0;
        chk("t2_drain", busy, 1);
        tick();
        chk("t2_idle", busy, 0);
        sb_check("t2_sb");

        // Timeout on client 0
        exp_q.push_back(8'hEE);
        send_cmd(8'h11);
        tick();
        n = 0;
        while (client_activate[0] && n < 200) begin
            n++;
            tick();
        end
        chk("t3_act_cycles", n, 100);
        chk("t3_err", err_count, 2);
        tick();
        chk("t3_tx_start", tx_start, 1);
        chk("t3_tx_data", tx_data, 8'hEE);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("t3_idle", busy, 0);
        sb_check("t3_sb");

        // Done on the timeout cycle wins
        send_cmd(8'h11);
        tick();
        for (int i = 0; i < 99; i++) tick();
        chk("t4_still_active", client_activate, 5'b00001);
        client_done[0] = 1'b1;
        tick();
        client_done = '0;
        chk("t4_act_off", client_activate, 0);
        chk("t4_err_same", err_count, 2);
        tick();
        chk("t4_idle", busy, 0);
        tick();
        tick();
        sb_check("t4_sb");

        // Reset mid-run with client 2 active
        send_cmd(8'h22);
        tick();
        chk("t5_act", client_activate, 5'b00100);
        client_tx_data[2*W +: W] = 8'h77;
        client_tx_start[2]       = 1'b1;
        exp_q.push_back(8'h77);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_rst_act", client_activate, 0);
        chk("t5_rst_tx_start", tx_start, 0);
        chk("t5_rst_tx_data", tx_data, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cur_cmd", cur_cmd, 0);
        chk("t5_rst_err", err_count, 0);
        client_tx_start = '0;
        reset           = 1'b1;
        tick();
        send_cmd(8'h22);
        tick();
        chk("t5_redispatch", client_activate, 5'b00100);
        chk("t5_cur_cmd", cur_cmd, 8'h22);
        client_done[2] = 1'b1;
        tick();
        client_done = '0;
        tick();
        chk("t5_idle", busy, 0);
        sb_check("t5_sb");

        // Duplicate code resolves to lowest index
        send_cmd(8'h21);
        tick();
        chk("t6_dup_act", d2_activate, 5'b00010);
        chk("t6_main_act", client_activate, 5'b00010);
        client_done[1] = 1'b1;
        tick();
        client_done = '0;
        tick();
        chk("t6_dup_idle", d2_busy, 0);

        // 8'h00 is a no-op
        send_cmd(8'h00);
        chk("t7_nop_busy", busy, 0);
        tick();
        chk("t7_nop_busy2", busy, 0);
        sb_check("t7_sb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
